// File: rtl/ecg_uart_sample_rx_if.sv
// Sample interface between the UART sample receiver and its consumer
// (alg_core). Carries the serial input line and the reassembled sample
// stream with its status strobes. When ECG_RX_PARITY_EN is defined the
// interface also carries the parity_err strobe.
interface ecg_uart_sample_rx_if #(
  parameter int SAMPLE_W = 11
);
  logic                sin;
  logic [SAMPLE_W-1:0] ecg_value;
  logic                data_valid;
  logic                frame_err;
  logic                sync_err;
  logic [15:0]         sample_cnt;
`ifdef ECG_RX_PARITY_EN
  logic                parity_err;
`endif

  // Receiver side: takes the line, produces samples and strobes.
  modport master (
    input  sin,
    output ecg_value,
    output data_valid,
    output frame_err,
    output sync_err,
    output sample_cnt
`ifdef ECG_RX_PARITY_EN
    ,
    output parity_err
`endif
  );

  // Consumer side (alg_core): reads samples and strobes.
  modport slave (
    input ecg_value,
    input data_valid,
    input frame_err,
    input sync_err,
    input sample_cnt
`ifdef ECG_RX_PARITY_EN
    ,
    input parity_err
`endif
  );
endinterface

// File: rtl/ecg_uart_sample_rx.sv
// UART front end for the heart-rate core. Receives 8N1 bytes on sin,
// reassembles 11-bit ECG samples from {high byte, low byte} pairs and
// emits each with a one-cycle data_valid strobe.
// Optional feature macro: ECG_RX_PARITY_EN -- frame becomes 8E1 and a
// parity_err strobe is added to the interface.
module ecg_uart_sample_rx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int SAMPLE_W    = 11
) (
  input logic                  clk,
  input logic                  rst,
  ecg_uart_sample_rx_if.master bus
);

  localparam int DIV   = CLK_FREQ_HZ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int BTC_W = $clog2(DIV);

  generate
    if (DIV < 16) begin : g_div_check
      $error("ecg_uart_sample_rx: CLK_FREQ_HZ/BAUD must be >= 16");
    end
    if (SAMPLE_W != 11) begin : g_width_check
      $error("ecg_uart_sample_rx: only SAMPLE_W = 11 is supported");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef ECG_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 s_meta, s;
  logic [BTC_W-1:0]     btc;
  logic [2:0]           bit_idx;
  logic [7:0]           shreg;
  logic                 bit_end, half_end;
  logic                 btc_clr, shift_en, byte_done;

  logic                 pending_q;
  logic [3:0]           hi_q;
  logic [SAMPLE_W-1:0]  ecg_q;
  logic [15:0]          sample_cnt_q;
  logic                 data_valid_q, frame_err_q, sync_err_q;

`ifdef ECG_RX_PARITY_EN
  logic                 par_en, par_bad_q, parity_err_q;
`endif

  assign bit_end  = (btc == BTC_W'(DIV - 1));
  assign half_end = (btc == BTC_W'(HALF - 1));

  // Two-flop synchronizer on the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_meta <= 1'b1;
      s      <= 1'b1;
    end else begin
      // NOTE: non-blocking so each stage captures the previous stage's old value.
      s_meta <= bus.sin;
      s      <= s_meta;
    end
  end

  // Byte FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Byte FSM next state and per-cycle control pulses.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d   = state_q;
    btc_clr   = 1'b0;
    shift_en  = 1'b0;
    byte_done = 1'b0;
`ifdef ECG_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!s) begin
          btc_clr = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (half_end) begin
          btc_clr = 1'b1;
          state_d = s ? ST_IDLE : ST_DATA;   // high at mid-start: glitch
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          btc_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef ECG_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef ECG_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          btc_clr = 1'b1;
          par_en  = 1'b1;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          btc_clr   = 1'b1;
          byte_done = 1'b1;
          state_d   = ST_IDLE;                // no idle time needed before next start
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit timing counter, bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      btc     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (btc_clr || state_q == ST_IDLE) btc <= '0;
      else                               btc <= btc + 1'b1;

      if (state_q == ST_START) bit_idx <= '0;
      else if (shift_en)       bit_idx <= bit_idx + 1'b1;

      if (shift_en) shreg <= {s, shreg[7:1]};
    end
  end

`ifdef ECG_RX_PARITY_EN
  // Even parity: data bits plus parity bit must hold an even number of ones.
  always_ff @(posedge clk) begin
    if (rst)         par_bad_q <= 1'b0;
    else if (par_en) par_bad_q <= (^shreg) ^ s;
  end
`endif

  // Framer: validates each received byte and assembles samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= 1'b0;
      hi_q         <= '0;
      ecg_q        <= '0;
      sample_cnt_q <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      sync_err_q   <= 1'b0;
`ifdef ECG_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      sync_err_q   <= 1'b0;
`ifdef ECG_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (byte_done) begin
        if (!s) begin
          frame_err_q <= 1'b1;                // stop bit low: byte discarded
`ifdef ECG_RX_PARITY_EN
        end else if (par_bad_q) begin
          parity_err_q <= 1'b1;
`endif
        end else if (shreg[7]) begin
          if (shreg[6:4] != 3'b000) begin
            sync_err_q <= 1'b1;               // malformed high byte
          end else begin
            hi_q      <= shreg[3:0];
            pending_q <= 1'b1;
            if (pending_q) sync_err_q <= 1'b1; // earlier high nibble lost
          end
        end else if (pending_q) begin
          ecg_q        <= {hi_q, shreg[6:0]};
          data_valid_q <= 1'b1;
          sample_cnt_q <= sample_cnt_q + 16'd1;
          pending_q    <= 1'b0;
        end else begin
          sync_err_q <= 1'b1;                 // low byte without a high byte
        end
      end
    end
  end

  assign bus.ecg_value  = ecg_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.sample_cnt = sample_cnt_q;
`ifdef ECG_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_ecg_uart_sample_rx.sv
// Directed bench for ecg_uart_sample_rx at DIV = 100 (100 MHz, 1 Mbaud).
// Strobes are counted by a monitor on the falling edge; expected values
// are hand-computed from the byte protocol.
module tb_ecg_uart_sample_rx;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int DIV    = CLK_HZ / BAUD;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ecg_uart_sample_rx_if #(.SAMPLE_W(11)) bus ();

  ecg_uart_sample_rx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD       (BAUD),
    .SAMPLE_W   (11)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor state.
  int          cyc    = 0;
  int          n_dv   = 0;
  int          n_fe   = 0;
  int          n_se   = 0;
  int          dv_cyc = 0;
  logic [10:0] last_ecg = '0;
  int          t_start = 0;
`ifdef ECG_RX_PARITY_EN
  int          n_pe     = 0;
  logic        par_flip = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.data_valid) begin
      n_dv     <= n_dv + 1;
      dv_cyc   <= cyc;
      last_ecg <= bus.ecg_value;
    end
    if (bus.frame_err) n_fe <= n_fe + 1;
    if (bus.sync_err)  n_se <= n_se + 1;
`ifdef ECG_RX_PARITY_EN
    if (bus.parity_err) n_pe <= n_pe + 1;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive_bit(input logic v);
    bus.sin = v;
    repeat (DIV) @(negedge clk);
  endtask

  // One UART frame starting at a falling edge; line returns high after.
  task automatic send_raw(input logic [7:0] b, input logic stop);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef ECG_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop);
    bus.sin = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_raw(b, 1'b1);
  endtask

  task automatic idle(input int n);
    bus.sin = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int dv0, fe0, se0;

  task automatic snap();
    dv0 = n_dv; fe0 = n_fe; se0 = n_se;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sin = 1'b1;
    repeat (5) @(negedge clk);

    // Reset values while rst is held.
    check("rst_ecg",  32'(bus.ecg_value), 32'h0);
    check("rst_dv",   32'(bus.data_valid), 32'h0);
    check("rst_fe",   32'(bus.frame_err), 32'h0);
    check("rst_se",   32'(bus.sync_err), 32'h0);
    check("rst_cnt",  32'(bus.sample_cnt), 32'h0);
    rst = 1'b0;
    idle(20);

    // Lone low byte after reset.
    snap();
    send_byte(8'h35);
    idle(20);
    check("lone_low_se", 32'(n_se - se0), 32'd1);
    check("lone_low_dv", 32'(n_dv - dv0), 32'd0);

    // Basic sample, back-to-back bytes, with latency from low-byte start.
    snap();
    send_byte(8'h8A);
    send_byte(8'h35);
    idle(20);
    check("s1_dv",  32'(n_dv - dv0), 32'd1);
    check("s1_ecg", 32'(last_ecg), 32'h535);
    check("s1_hold", 32'(bus.ecg_value), 32'h535);
    check("s1_cnt", 32'(bus.sample_cnt), 32'd1);
    check("s1_err", 32'((n_se - se0) + (n_fe - fe0)), 32'd0);
    check("s1_lat", 32'(dv_cyc - t_start), 32'd953);

    // Extremes of the sample range.
    send_byte(8'h8F);
    send_byte(8'h7F);
    idle(20);
    check("max_ecg", 32'(last_ecg), 32'h7FF);
    send_byte(8'h80);
    send_byte(8'h00);
    idle(20);
    check("min_ecg", 32'(bus.ecg_value), 32'h000);
    check("min_cnt", 32'(bus.sample_cnt), 32'd3);

    // Repeated high byte: second replaces the first.
    snap();
    send_byte(8'h81);
    send_byte(8'h82);
    send_byte(8'h01);
    idle(20);
    check("rehi_se",  32'(n_se - se0), 32'd1);
    check("rehi_dv",  32'(n_dv - dv0), 32'd1);
    check("rehi_ecg", 32'(last_ecg), 32'h101);

    // High byte with nonzero bits[6:4].
    snap();
    send_byte(8'h9A);
    idle(20);
    check("badhi_se", 32'(n_se - se0), 32'd1);

    // Stop bit low, then a normal sample (pending must be untouched).
    snap();
    send_raw(8'h8A, 1'b0);
    idle(200);
    check("ferr_fe", 32'(n_fe - fe0), 32'd1);
    check("ferr_dv", 32'(n_dv - dv0), 32'd0);
    send_byte(8'h8A);
    send_byte(8'h35);
    idle(20);
    check("ferr_after_ecg", 32'(last_ecg), 32'h535);
    check("ferr_after_se",  32'(n_se - se0), 32'd0);
    check("ferr_after_dv",  32'(n_dv - dv0), 32'd1);

    // Short low glitch on the line.
    snap();
    bus.sin = 1'b0;
    repeat (30) @(negedge clk);
    idle(200);
    check("glitch_strobes", 32'((n_dv - dv0) + (n_fe - fe0) + (n_se - se0)), 32'd0);
    check("glitch_idle", 32'(dut.state_q), 32'd0);

    // Reset after a high byte discards the pending nibble.
    send_byte(8'h8A);
    idle(10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ecg", 32'(bus.ecg_value), 32'h0);
    check("mid_rst_cnt", 32'(bus.sample_cnt), 32'h0);
    check("mid_rst_dv",  32'(bus.data_valid), 32'h0);
    idle(10);
    snap();
    send_byte(8'h35);
    idle(20);
    check("mid_rst_se", 32'(n_se - se0), 32'd1);
    check("mid_rst_nodv", 32'(n_dv - dv0), 32'd0);

    // Sample counter wrap.
    force dut.sample_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.sample_cnt_q;
    @(negedge clk);
    check("wrap_pre", 32'(bus.sample_cnt), 32'hFFFF);
    send_byte(8'h8A);
    send_byte(8'h35);
    idle(20);
    check("wrap_cnt", 32'(bus.sample_cnt), 32'h0000);
    check("wrap_ecg", 32'(bus.ecg_value), 32'h535);

`ifdef ECG_RX_PARITY_EN
    // Wrong parity drops the byte and leaves pending clear.
    snap();
    par_flip = 1'b1;
    send_byte(8'h8A);
    par_flip = 1'b0;
    idle(20);
    check("par_pe", 32'(n_pe), 32'd1);
    check("par_dv", 32'(n_dv - dv0), 32'd0);
    send_byte(8'h35);
    idle(20);
    check("par_after_se", 32'(n_se - se0), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
